// File: rtl/sipo_16_bit_deser_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // state  | meaning
    // IDLE   | waiting for a sample flagged with sin_sof
    // DATA   | collecting data bits into the shift register
    // PARITY | next sample is the even-parity bit for the frame
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } sipo_state_e;

endpackage

// File: rtl/sipo_16_bit_deser.sv
// Serial-to-parallel deserializer with even-parity check and frame restart on sin_sof.
module sipo_16_bit_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_sof,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             par_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    sipo_state_e      state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_acc_q, par_acc_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             par_err_q, par_err_d;
    logic             frame_err_q, frame_err_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic [CW-1:0]    cnt_inc;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        par_err_d    = 1'b0;
        frame_err_d  = 1'b0;

        // Bit order is fixed by which end new bits enter the shift register.
        if (MSB_FIRST) begin
            shifted    = {shift_q[WIDTH-2:0], sin_data};
            first_word = {{(WIDTH-1){1'b0}}, sin_data};
        end else begin
            shifted    = {sin_data, shift_q[WIDTH-1:1]};
            first_word = {sin_data, {(WIDTH-1){1'b0}}};
        end
        cnt_inc = bit_cnt_q + CW'(1);

        if (sin_valid) begin
            if (sin_sof) begin
                // Any sof starts a fresh frame; outside IDLE it also drops the partial one.
                shift_d     = first_word;
                par_acc_d   = sin_data;
                bit_cnt_d   = CW'(1);
                state_d     = (CW'(1) == CW'(WIDTH)) ? PARITY : DATA;
                frame_err_d = (state_q != IDLE);
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    DATA: begin
                        shift_d   = shifted;
                        par_acc_d = par_acc_q ^ sin_data;
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == CW'(WIDTH)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        par_acc_d = 1'b0;
                        if (par_acc_q == sin_data) begin
                            word_d       = shift_q;
                            word_valid_d = 1'b1;
                        end else begin
                            par_err_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            par_err_q    <= par_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign par_err    = par_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_16_bit_deser.sv
// Directed bench for sipo_16_bit_deser: good, gapped, bad-parity, restart, reset and back-to-back frames.
module tb_sipo_16_bit_deser;

    logic        clk;
    logic        reset_n;
    logic        sin_valid;
    logic        sin_data;
    logic        sin_sof;
    logic [15:0] word_out;
    logic        word_valid;
    logic        par_err;
    logic        frame_err;
    logic        busy;

    int n_cmp;
    int n_bad;
    int cyc;
    int wv_count;
    int pe_count;
    int fe_count;
    int wv_last;
    int wv_prev;

    sipo_16_bit_deser #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sin_valid (sin_valid),
        .sin_data  (sin_data),
        .sin_sof   (sin_sof),
        .word_out  (word_out),
        .word_valid(word_valid),
        .par_err   (par_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample slot: inputs change 1ns after a rising edge, outputs are read 1ns after the next one.
    task automatic drive(input logic v, input logic d, input logic s);
        sin_valid = v;
        sin_data  = d;
        sin_sof   = s;
        @(posedge clk);
        #1;
        cyc++;
        if (word_valid) begin
            wv_count++;
            wv_prev = wv_last;
            wv_last = cyc;
        end
        if (par_err)   pe_count++;
        if (frame_err) fe_count++;
        if ((32'(word_valid) + 32'(par_err) + 32'(frame_err)) > 1)
            check("pulse_exclusive", {29'd0, word_valid, par_err, frame_err}, 32'd0);
    endtask

    // gap_a / gap_b: after this many data bits, insert three invalid cycles (0 disables).
    task automatic send_frame(input logic [15:0] w, input logic par, input int gap_a, input int gap_b);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, w[15-i], (i == 0));
            if ((gap_a != 0 && i + 1 == gap_a) || (gap_b != 0 && i + 1 == gap_b))
                for (int g = 0; g < 3; g++) drive(1'b0, 1'b1, 1'b1);
        end
        drive(1'b1, par, 1'b0);
    endtask

    int start_cyc;
    int wv0, pe0, fe0;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        wv_count = 0; pe_count = 0; fe_count = 0; wv_last = 0; wv_prev = 0;
        sin_valid = 1'b0; sin_data = 1'b0; sin_sof = 1'b0;
        reset_n = 1'b0;
        #22;
        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_flags", {28'd0, word_valid, par_err, frame_err, busy}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Good frame 0xA5C3, parity 0.
        start_cyc = cyc;
        send_frame(16'hA5C3, 1'b0, 0, 0);
        check("good_wv_now", 32'(word_valid), 32'd1);
        check("good_word", 32'(word_out), 32'hA5C3);
        check("good_latency", 32'(wv_last - start_cyc), 32'd17);
        check("good_busy_idle", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        check("good_wv_one_cycle", 32'(word_valid), 32'd0);
        check("good_wv_count", 32'(wv_count), 32'd1);

        // Same frame with two 3-cycle gaps.
        start_cyc = cyc;
        send_frame(16'hA5C3, 1'b0, 4, 15);
        check("gap_wv", 32'(word_valid), 32'd1);
        check("gap_word", 32'(word_out), 32'hA5C3);
        check("gap_latency", 32'(wv_last - start_cyc), 32'd23);
        check("gap_wv_count", 32'(wv_count), 32'd2);

        // Bad parity: 0x0001 needs parity 1.
        send_frame(16'h0001, 1'b0, 0, 0);
        check("badpar_pe", 32'(par_err), 32'd1);
        check("badpar_wv", 32'(word_valid), 32'd0);
        check("badpar_word_hold", 32'(word_out), 32'hA5C3);
        drive(1'b0, 1'b0, 1'b0);
        check("badpar_pe_count", 32'(pe_count), 32'd1);
        check("badpar_wv_count", 32'(wv_count), 32'd2);

        // Restart: 6 bits of a frame, then sof on the 7th sample starting 0x1234.
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
        fe0 = fe_count;
        drive(1'b1, 1'b0, 1'b1);
        check("restart_fe_pulse", 32'(frame_err), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 16; i++) drive(1'b1, 1'(16'h1234 >> (15 - i)), 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("restart_wv", 32'(word_valid), 32'd1);
        check("restart_word", 32'(word_out), 32'h1234);
        check("restart_fe_count", 32'(fe_count - fe0), 32'd1);

        // Reset after 9 bits of a frame.
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, (i == 0));
        check("prerst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_word_out", 32'(word_out), 32'h0);
        check("midrst_flags", {28'd0, word_valid, par_err, frame_err, busy}, 32'h0);
        sin_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        wv0 = wv_count; pe0 = pe_count; fe0 = fe_count;
        drive(1'b1, 1'b1, 1'b0);
        check("postrst_wait_sof", 32'(busy), 32'd0);
        send_frame(16'hFFFF, 1'b0, 0, 0);
        check("postrst_word", 32'(word_out), 32'hFFFF);
        check("postrst_wv", 32'(wv_count - wv0), 32'd1);
        check("postrst_no_err", 32'((pe_count - pe0) + (fe_count - fe0)), 32'd0);

        // Back-to-back 0x8000 (p=1) then 0x7FFF (p=1).
        wv0 = wv_count;
        send_frame(16'h8000, 1'b1, 0, 0);
        check("b2b_first_word", 32'(word_out), 32'h8000);
        send_frame(16'h7FFF, 1'b1, 0, 0);
        check("b2b_second_word", 32'(word_out), 32'h7FFF);
        check("b2b_count", 32'(wv_count - wv0), 32'd2);
        check("b2b_spacing", 32'(wv_last - wv_prev), 32'd17);
        drive(1'b0, 1'b0, 1'b0);
        check("final_idle", {28'd0, word_valid, par_err, frame_err, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sipo_16_bit_deser.md
SIPO_16_BIT_DESER -- requirements
Module: sipo_16_bit_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of data bits per frame and the width of word_out.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 means the first data bit lands in word_out[WIDTH-1]; 0 means it lands in word_out[0].
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sin_valid, input, 1 bit: sin_data and sin_sof are sampled only when sin_valid is high.
REQ-006 The block SHALL have port sin_data, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port sin_sof, input, 1 bit: marks the first data bit of a frame; qualified by sin_valid.
REQ-008 The block SHALL have port word_out, output, WIDTH bits: the last good assembled word; intended to drive the downstream PIPO register d_in.
REQ-009 The block SHALL have port word_valid, output, 1 bit: one-cycle pulse when word_out updates; intended to drive the downstream PIPO En.
REQ-010 The block SHALL have port par_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when sin_sof arrives mid-frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The frame format SHALL be: WIDTH data bits (first bit flagged by sin_sof), then one even-parity bit, each delivered on a sin_valid cycle; parity of the data bits plus the parity bit SHALL equal 0.
REQ-014 The FSM SHALL have exactly three states: IDLE, DATA and PARITY.
REQ-015 In IDLE, a sample with sin_sof=1 SHALL capture bit 0 into the shift register, set bit_cnt to 1 and move to DATA; samples with sin_sof=0 SHALL be ignored.
REQ-016 In DATA, each sample SHALL shift in one bit and increment bit_cnt; when bit_cnt reaches WIDTH, the FSM SHALL move to PARITY.
REQ-017 In PARITY, the sample SHALL be compared against the accumulated parity, and the FSM SHALL return to IDLE.
REQ-018 On a parity match, in the cycle after the parity sample, word_out SHALL take the shift register value and word_valid SHALL pulse for exactly one cycle.
REQ-019 On a parity mismatch, par_err SHALL pulse for one cycle, word_out SHALL hold its previous value and word_valid SHALL stay low.
REQ-020 A cycle with sin_valid=0 SHALL leave the state, bit_cnt, the shift register and the parity accumulator unchanged (gaps are allowed anywhere).
REQ-021 A sample with sin_sof=1 while in DATA or PARITY SHALL pulse frame_err one cycle later, discard the partial frame, and restart with that sample taken as bit 0 (state DATA, bit_cnt=1).
REQ-022 A parity bit sampled with sin_sof=1 SHALL be treated as a restart per REQ-021, not as a parity bit.
REQ-023 Back-to-back frames SHALL be supported: sin_sof on the sample immediately after the parity sample SHALL be accepted with no lost bits.
REQ-024 Latency from the parity sample to word_valid SHALL be exactly 1 clk.
REQ-025 word_valid, par_err and frame_err SHALL be registered outputs and SHALL never be high at the same time.

Reset
REQ-026 On reset_n low, asynchronously: state SHALL be IDLE, bit_cnt, the shift register, the parity accumulator and word_out SHALL be 0, and word_valid, par_err, frame_err and busy SHALL be 0.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame with no error pulse; after release, the block SHALL wait for sin_sof.
REQ-028 All sequential elements SHALL use the same asynchronous reset; no state SHALL depend on reset-release timing other than starting in IDLE.

Structure
REQ-029 A shared package sipo_pkg SHALL hold the state enum (IDLE, DATA, PARITY) and the constant DEFAULT_WIDTH=16.
REQ-030 bit_cnt SHALL be $clog2(WIDTH+1) bits wide.
REQ-031 The block SHALL be a single module with no sub-modules; the shift register, counter and parity XOR SHALL be inline.

Verification
REQ-032 The bench SHALL cover a good frame: send 0xA5C3 MSB-first with sof on the first bit, then parity 0 -> word_valid pulses once, 1 clk after the parity sample, with word_out=0xA5C3.
REQ-033 The bench SHALL cover gaps: send the same frame with sin_valid deasserted for 3 cycles after bits 4 and 15 -> word_out=0xA5C3, with word_valid delayed by exactly 6 cycles.
REQ-034 The bench SHALL cover bad parity: send 0x0001 with parity 0 -> par_err pulses, word_out keeps its prior value (0xA5C3), and word_valid stays 0.
REQ-035 The bench SHALL cover a mid-frame restart: send sof at bit 7, then a full 0x1234 frame with parity 1 -> frame_err pulses once, then word_out=0x1234.
REQ-036 The bench SHALL cover reset mid-frame: assert reset_n low after 9 bits -> all outputs 0 immediately; a subsequent 0xFFFF frame with parity 0 yields word_out=0xFFFF and no error pulse.
REQ-037 The bench SHALL cover back-to-back frames: 0x8000 (parity 1) immediately followed by 0x7FFF (parity 1) with no idle cycles -> two word_valid pulses exactly 17 sample cycles apart.
